// File: rtl/register_file_mp.sv
// Register file: two combinational read ports, one write port, optional r0=0 and write bypass, sweep clear.
// Reads are zero latency and writes land on the next edge; writes are dropped and flagged while a clear is running.
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] r_reg1,
  input  logic [ADDR_W-1:0] r_reg2,
  output logic [DATA_W-1:0] r_data1,
  output logic [DATA_W-1:0] r_data2,
  input  logic [ADDR_W-1:0] w_reg_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              reg_w,
  input  logic              clr,
  output logic              busy,
  output logic              clr_done,
  output logic              w_rejected
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int PTR_W    = ADDR_W + 1;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [DATA_W-1:0]  r_mem [NUM_REGS];
  logic               r_busy;
  logic               r_clr_done;
  logic               r_w_rejected;

  logic w_wr_is_r0;
  logic w_fwd_ok;
  logic w_rd1_is_r0;
  logic w_rd2_is_r0;

  assign w_wr_is_r0  = (ZERO_REG != 0) && (w_reg_addr == '0);
  assign w_rd1_is_r0 = (ZERO_REG != 0) && (r_reg1 == '0);
  assign w_rd2_is_r0 = (ZERO_REG != 0) && (r_reg2 == '0);

  // Forwarding only when the write will actually commit at this edge.
  assign w_fwd_ok = (BYPASS != 0) && (r_state == ST_IDLE) && !clr && reg_w && !w_wr_is_r0;

  assign r_data1 = r_busy ? '0 :
                   w_rd1_is_r0 ? '0 :
                   (w_fwd_ok && (r_reg1 == w_reg_addr)) ? w_data : r_mem[r_reg1];

  assign r_data2 = r_busy ? '0 :
                   w_rd2_is_r0 ? '0 :
                   (w_fwd_ok && (r_reg2 == w_reg_addr)) ? w_data : r_mem[r_reg2];

  assign busy       = r_busy;
  assign clr_done   = r_clr_done;
  assign w_rejected = r_w_rejected;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_busy       <= 1'b0;
      r_clr_done   <= 1'b0;
      r_w_rejected <= 1'b0;
    end else begin
      r_clr_done   <= 1'b0;
      r_w_rejected <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clr) begin
            r_state      <= ST_CLEAR;
            r_ptr        <= '0;
            r_busy       <= 1'b1;
            r_w_rejected <= reg_w;
          end else if (reg_w && !w_wr_is_r0) begin
            r_mem[w_reg_addr] <= w_data;
          end
        end
        ST_CLEAR: begin
          // clr is ignored here: a sweep is never restarted or extended.
          r_mem[r_ptr[ADDR_W-1:0]] <= '0;
          r_w_rejected             <= reg_w;
          if (r_ptr == PTR_W'(NUM_REGS - 1)) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_busy     <= 1'b0;
            r_clr_done <= 1'b1;
          end else begin
            r_ptr <= r_ptr + PTR_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: default instance plus a BYPASS=0/ZERO_REG=0 instance on shared inputs.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  r_reg1, r_reg2, w_reg_addr;
  logic [31:0] w_data;
  logic        reg_w, clr;
  logic [31:0] r_data1, r_data2, r_data1_nb, r_data2_nb;
  logic        busy, clr_done, w_rejected;
  logic        busy_nb, clr_done_nb, w_rejected_nb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .r_reg1(r_reg1), .r_reg2(r_reg2),
    .r_data1(r_data1), .r_data2(r_data2), .w_reg_addr(w_reg_addr), .w_data(w_data),
    .reg_w(reg_w), .clr(clr), .busy(busy), .clr_done(clr_done), .w_rejected(w_rejected)
  );

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .r_reg1(r_reg1), .r_reg2(r_reg2),
    .r_data1(r_data1_nb), .r_data2(r_data2_nb), .w_reg_addr(w_reg_addr), .w_data(w_data),
    .reg_w(reg_w), .clr(clr), .busy(busy_nb), .clr_done(clr_done_nb), .w_rejected(w_rejected_nb)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] enb;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] enb;
  } exp_t;

  vec_t vt [8];
  exp_t q_exp [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_w = 1'b1; w_reg_addr = a; w_data = d;
    tick();
    reg_w = 1'b0;
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    if (q_exp.size() == 0) begin
      chk({nm, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = q_exp.pop_front();
      chk({nm, "_rd1"}, r_data1, e.e1);
      chk({nm, "_rd2"}, r_data2, e.e2);
      chk({nm, "_nb_rd1"}, r_data1_nb, e.enb);
    end
  endtask

  initial begin
    int k;
    logic bad;
    exp_t e;

    vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    vt[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[2] = '{1'b1, 5'd7,  32'h1234,     5'd7,  5'd5, 32'h1234,     32'hDEADBEEF, 32'h0};
    vt[3] = '{1'b1, 5'd7,  32'h5678,     5'd7,  5'd7, 32'h5678,     32'h5678,     32'h1234};
    vt[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7, 32'h0,        32'h5678,     32'h0};
    vt[5] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0, 32'h0,        32'h0,        32'hFFFFFFFF};
    vt[6] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd0, 32'hA5A5A5A5, 32'h0,        32'h0};
    vt[7] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd1, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5};

    rst = 1'b1; reg_w = 1'b0; clr = 1'b0; w_reg_addr = '0; w_data = '0;
    r_reg1 = 5'd1; r_reg2 = 5'd2;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_clr_done", {31'd0, clr_done}, 32'd0);
    chk("rst_w_rejected", {31'd0, w_rejected}, 32'd0);
    chk("rst_rd1", r_data1, 32'd0);
    #10 rst = 1'b0;
    tick();

    // Table: writes, same-edge bypass, r0 behaviour, identical dual reads.
    for (int i = 0; i < 8; i++) begin
      reg_w = vt[i].we; w_reg_addr = vt[i].wa; w_data = vt[i].wd;
      r_reg1 = vt[i].a1; r_reg2 = vt[i].a2;
      e.e1 = vt[i].e1; e.e2 = vt[i].e2; e.enb = vt[i].enb;
      q_exp.push_back(e);
      #3;
      pop_check($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_w_rejected", i), {31'd0, w_rejected}, 32'd0);
      tick();
    end
    reg_w = 1'b0;

    // Fill r1..r31 with their index, then read back through both ports.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    for (int i = 0; i < 32; i++) begin
      r_reg1 = 5'(i); r_reg2 = 5'(31 - i);
      e.e1  = (i == 0) ? 32'd0 : 32'(i);
      e.e2  = (i == 31) ? 32'd0 : 32'(31 - i);
      e.enb = (i == 0) ? 32'hFFFFFFFF : 32'(i);
      q_exp.push_back(e);
      #1;
      pop_check($sformatf("fill%0d", i));
    end

    // Single clr pulse: 32 busy cycles, reads masked, one-cycle done.
    r_reg1 = 5'd31; r_reg2 = 5'd31; clr = 1'b1;
    #2;
    chk("sweep_busy_before_edge", {31'd0, busy}, 32'd0);
    tick();
    clr = 1'b0;
    k = 0;
    while (busy && k < 100) begin
      chk($sformatf("sweep_mask_rd1_k%0d", k), r_data1, 32'd0);
      if (k == 0) chk("sweep_nb_mask_rd1", r_data1_nb, 32'd0);
      if (k == 5) chk("sweep_clr_done_mid", {31'd0, clr_done}, 32'd0);
      k++;
      tick();
    end
    chk("sweep_busy_cycles", 32'(k), 32'd32);
    chk("sweep_clr_done_pulse", {31'd0, clr_done}, 32'd1);
    chk("sweep_nb_clr_done_pulse", {31'd0, clr_done_nb}, 32'd1);
    tick();
    chk("sweep_clr_done_one_cycle", {31'd0, clr_done}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 32; i++) begin
      r_reg1 = 5'(i); r_reg2 = 5'(i);
      #1;
      if (r_data1 !== 32'd0 || r_data2 !== 32'd0 || r_data1_nb !== 32'd0 || r_data2_nb !== 32'd0) bad = 1'b1;
    end
    chk("sweep_all_zero", {31'd0, bad}, 32'd0);

    // Write coincident with clr, then write+clr again mid-sweep after r3 was swept.
    wr(5'd3, 32'h77);
    r_reg1 = 5'd3;
    clr = 1'b1; reg_w = 1'b1; w_reg_addr = 5'd9; w_data = 32'h99;
    tick();
    clr = 1'b0; reg_w = 1'b0;
    k = 0;
    while (busy && k < 100) begin
      if (k == 0) chk("t6_rej_coincident", {31'd0, w_rejected}, 32'd1);
      if (k == 0) chk("t6_nb_rej_coincident", {31'd0, w_rejected_nb}, 32'd1);
      if (k == 1) chk("t6_rej_clears", {31'd0, w_rejected}, 32'd0);
      if (k == 11) chk("t6_rej_midsweep", {31'd0, w_rejected}, 32'd1);
      if (k == 12) chk("t6_rej_midsweep_one", {31'd0, w_rejected}, 32'd0);
      if (k == 10) begin
        reg_w = 1'b1; w_reg_addr = 5'd3; w_data = 32'h55; clr = 1'b1;
      end else begin
        reg_w = 1'b0; clr = 1'b0;
      end
      k++;
      tick();
    end
    reg_w = 1'b0; clr = 1'b0;
    chk("t6_busy_cycles", 32'(k), 32'd32);
    #1;
    chk("t6_r3_zero", r_data1, 32'd0);
    chk("t6_nb_r3_zero", r_data1_nb, 32'd0);

    // clr held high: exactly one idle cycle between back-to-back sweeps.
    clr = 1'b1;
    tick();
    k = 0;
    while (busy && k < 100) begin
      k++;
      tick();
    end
    chk("hold_first_cycles", 32'(k), 32'd32);
    chk("hold_gap_done", {31'd0, clr_done}, 32'd1);
    tick();
    chk("hold_restart_busy", {31'd0, busy}, 32'd1);
    clr = 1'b0;
    k = 0;
    while (busy && k < 100) begin
      k++;
      tick();
    end
    chk("hold_second_cycles", 32'(k), 32'd32);

    // Async reset mid-sweep at ptr=10.
    wr(5'd20, 32'hCAFE);
    r_reg1 = 5'd20;
    #1;
    chk("t1_pre_r20", r_data1, 32'hCAFE);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2 rst = 1'b1;
    #1;
    chk("t1_busy_async", {31'd0, busy}, 32'd0);
    chk("t1_nb_busy_async", {31'd0, busy_nb}, 32'd0);
    chk("t1_r20_zero", r_data1, 32'd0);
    chk("t1_nb_r20_zero", r_data1_nb, 32'd0);
    #8 rst = 1'b0;
    tick();
    bad = 1'b0;
    for (int i = 0; i < 35; i++) begin
      if (clr_done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("t1_no_done_after_rst", {31'd0, bad}, 32'd0);
    wr(5'd4, 32'h44);
    r_reg1 = 5'd4;
    #1;
    chk("t1_idle_write", r_data1, 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
